collision_multi_detector: RTL and testbench

//  Parametrised collision detector. Tests one rocket box against NUM_AST asteroid boxes

---
 rtl/collision_multi_detector.sv | 142 ++++++++++++++
 tb/tb_collision_multi_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/collision_multi_detector.sv
// collision_multi_detector
//   Tests one rocket box against NUM_AST asteroid boxes every PLAY cycle.
//   Every overlapping asteroid is destroyed in a single pulse, one life is
//   lost per collision event, and a non-fatal hit starts an invulnerability
//   cooldown. gameover is held once the lives are exhausted.
// Ports
//   clock, reset       rising-edge clock, asynchronous active-high reset
//   start              level; leaves IDLE/OVER and reloads lives
//   rocketx/rockety    rocket top-left corner
//   asteroidx/y        packed asteroid corners, channel i at [i*W +: W]
//   asteroid_active    per-channel valid; inactive channels never collide
//   destroyasteroid    one-cycle mask of asteroids hit
//   hit                one-cycle pulse per collision event
//   lives              remaining lives
//   invulnerable       high throughout the cooldown
//   gameover           high while the game is over
module collision_multi_detector #(
    parameter int NUM_AST  = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ROCKET_W = 4,
    parameter int ROCKET_H = 9,
    parameter int AST_W    = 4,
    parameter int AST_H    = 4,
    parameter int LIVES    = 3,
    parameter int COOLDOWN = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [X_W-1:0]         rocketx,
    input  logic [Y_W-1:0]         rockety,
    input  logic [NUM_AST*X_W-1:0] asteroidx,
    input  logic [NUM_AST*Y_W-1:0] asteroidy,
    input  logic [NUM_AST-1:0]     asteroid_active,
    output logic [NUM_AST-1:0]     destroyasteroid,
    output logic                   hit,
    output logic [3:0]             lives,
    output logic                   invulnerable,
    output logic                   gameover
);

    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0]  CD_LOAD    = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
    localparam logic [3:0]     LIVES_INIT = 4'(LIVES);
    localparam logic [X_W:0]   AST_W_E    = (X_W+1)'(AST_W);
    localparam logic [X_W:0]   ROCKET_W_E = (X_W+1)'(ROCKET_W);
    localparam logic [Y_W:0]   AST_H_E    = (Y_W+1)'(AST_H);
    localparam logic [Y_W:0]   ROCKET_H_E = (Y_W+1)'(ROCKET_H);

    typedef enum logic [2:0] {
        IDLE,
        PLAY,
        HIT,
        COOL,
        OVER
    } state_t;

    state_t             state, state_n;
    logic [3:0]         lives_q, lives_n;
    logic [NUM_AST-1:0] hit_mask, mask_n;
    logic [CW-1:0]      count, count_n;
    logic [NUM_AST-1:0] overlap;
    logic [X_W:0]       rx_e, ax_e;
    logic [Y_W:0]       ry_e, ay_e;

    // One extra bit on every operand so box-edge sums cannot wrap.
    always_comb begin
        overlap = '0;
        rx_e    = {1'b0, rocketx};
        ry_e    = {1'b0, rockety};
        ax_e    = '0;
        ay_e    = '0;
        for (int unsigned i = 0; i < NUM_AST; i++) begin
            ax_e = {1'b0, asteroidx[i*X_W +: X_W]};
            ay_e = {1'b0, asteroidy[i*Y_W +: Y_W]};
            overlap[i] = asteroid_active[i]
                       && (rx_e < ax_e + AST_W_E) && (ax_e < rx_e + ROCKET_W_E)
                       && (ry_e < ay_e + AST_H_E) && (ay_e < ry_e + ROCKET_H_E);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lives_q  <= '0;
            hit_mask <= '0;
            count    <= '0;
        end else begin
            state    <= state_n;
            lives_q  <= lives_n;
            hit_mask <= mask_n;
            count    <= count_n;
        end
    end

    always_comb begin
        state_n = state;
        lives_n = lives_q;
        mask_n  = hit_mask;
        count_n = count;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_n = PLAY;
                    lives_n = LIVES_INIT;
                end
            end
            PLAY: begin
                if (|overlap) begin
                    mask_n  = overlap;
                    state_n = HIT;
                end
            end
            HIT: begin
                // One life per event, however many asteroids were hit.
                lives_n = lives_q - 4'd1;
                if (lives_q == 4'd1) begin
                    state_n = OVER;
                end else if (COOLDOWN == 0) begin
                    state_n = PLAY;
                end else begin
                    state_n = COOL;
                    count_n = CD_LOAD;
                end
            end
            COOL: begin
                if (count == '0) state_n = PLAY;
                else             count_n = count - CW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them at once.
    assign destroyasteroid = (state == HIT) ? hit_mask : '0;
    assign hit             = (state == HIT);
    assign lives           = lives_q;
    assign invulnerable    = (state == COOL);
    assign gameover        = (state == OVER);

endmodule

// File: tb/tb_collision_multi_detector.sv
module tb_collision_multi_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rocketx;
    logic [6:0]  rockety;
    logic [31:0] asteroidx;
    logic [27:0] asteroidy;
    logic [3:0]  asteroid_active;
    logic [3:0]  destroyasteroid;
    logic        hit;
    logic [3:0]  lives;
    logic        invulnerable;
    logic        gameover;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] lives;
    } exp_t;
    exp_t exp_q[$];

    collision_multi_detector #(
        .NUM_AST(4), .X_W(8), .Y_W(7), .ROCKET_W(4), .ROCKET_H(9),
        .AST_W(4), .AST_H(4), .LIVES(3), .COOLDOWN(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .rocketx(rocketx), .rockety(rockety),
        .asteroidx(asteroidx), .asteroidy(asteroidy),
        .asteroid_active(asteroid_active),
        .destroyasteroid(destroyasteroid), .hit(hit), .lives(lives),
        .invulnerable(invulnerable), .gameover(gameover)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any pulse on the collision outputs must match the next queued event.
    always @(negedge clock) begin
        if (hit || destroyasteroid != 4'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_hit: destroy=%b hit=%b expected no pulse at %0t",
                         destroyasteroid, hit, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_hit", 32'(hit), 32'd1);
                chk("pulse_destroy", 32'(destroyasteroid), 32'(e.mask));
                chk("pulse_lives", 32'(lives), 32'(e.lives));
            end
        end
    end

    task automatic set_ast(input int ch, input int x, input int y, input logic act);
        logic [7:0] xv;
        logic [6:0] yv;
        xv = x[7:0];
        yv = y[6:0];
        asteroidx[ch*8 +: 8]  = xv;
        asteroidy[ch*7 +: 7]  = yv;
        asteroid_active[ch]   = act;
    endtask

    task automatic clear_ast();
        asteroidx = '0;
        asteroidy = '0;
        asteroid_active = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Offer one vector to a PLAY-state DUT; a hit is expected only if queued.
    task automatic vec(input int x, input int y, input logic expect_hit, input logic [3:0] lv);
        exp_t e;
        set_ast(0, x, y, 1'b1);
        if (expect_hit) begin
            e.mask  = 4'b0001;
            e.lives = lv;
            exp_q.push_back(e);
        end
        step(1);
        clear_ast();
        step(11);
    endtask

    initial begin
        exp_t e;
        reset   = 1'b1;
        start   = 1'b0;
        rocketx = 8'd40;
        rockety = 7'd100;
        clear_ast();
        #2;
        chk("reset_outputs", {23'd0, destroyasteroid, hit, lives, invulnerable, gameover}, 32'd0);
        step(2);
        reset = 1'b0;
        step(2);
        chk("idle_lives", 32'(lives), 32'd0);
        do_start();
        chk("start_lives", 32'(lives), 32'd3);
        chk("start_gameover", 32'(gameover), 32'd0);

        // Single channel: full overlap, then x/y boundaries around rocket (40,100) 4x9.
        vec(40, 100, 1'b1, 4'd3);
        chk("lives_after_hit1", 32'(lives), 32'd2);
        vec(44, 100, 1'b0, 4'd0);   // right gap
        vec(36, 100, 1'b0, 4'd0);   // left gap
        vec(43, 100, 1'b1, 4'd2);   // one shared column
        chk("lives_after_hit2", 32'(lives), 32'd1);
        vec(40, 96, 1'b0, 4'd0);    // asteroid rows 96..99, rocket starts at 100
        vec(40, 109, 1'b0, 4'd0);   // just below rocket rows 100..108
        vec(40, 97, 1'b1, 4'd1);    // shares row 100; last life
        chk("over_gameover", 32'(gameover), 32'd1);
        chk("over_lives", 32'(lives), 32'd0);
        step(3);
        chk("over_held", 32'(gameover), 32'd1);
        do_start();
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_gameover", 32'(gameover), 32'd0);

        // Two channels at once, inactive overlapping channel, persistent overlap.
        set_ast(0, 100, 50, 1'b1);
        set_ast(1, 42, 105, 1'b1);
        set_ast(2, 40, 100, 1'b0);
        set_ast(3, 38, 98, 1'b1);
        e.mask = 4'b1010; e.lives = 4'd3; exp_q.push_back(e);
        e.mask = 4'b1010; e.lives = 4'd2; exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);           // HIT cycle, checked by monitor
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("cool_invulnerable", 32'(invulnerable), 32'd1);
            chk("cool_no_hit", 32'(hit), 32'd0);
        end
        @(negedge clock);
        chk("cool_end", 32'(invulnerable), 32'd0);
        chk("lives_after_multi", 32'(lives), 32'd2);
        @(negedge clock);           // re-hit from persistent overlap
        @(negedge clock);
        chk("lives_after_rehit", 32'(lives), 32'd1);
        chk("rehit_cool", 32'(invulnerable), 32'd1);

        // Asynchronous reset between edges while in cooldown.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", {23'd0, destroyasteroid, hit, lives, invulnerable, gameover}, 32'd0);
        step(1);
        reset = 1'b0;
        step(4);                    // overlap still present, but IDLE ignores it
        chk("post_reset_lives", 32'(lives), 32'd0);
        e.mask = 4'b1010; e.lives = 4'd3; exp_q.push_back(e);
        do_start();
        chk("replay_lives", 32'(lives), 32'd3);
        step(3);
        clear_ast();
        step(12);
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
